// File: rtl/stage_m_mem.sv
// Memory stage of the 5-stage MIPS core: data-memory req/ack port, store alignment,
// load extension and the M/W pipeline register. Optional macro ALIGN_EXC_EN traps misaligned accesses.
module stage_m_mem #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_M,
    input  logic        valid_M,
    input  logic [31:0] v_ALUout_M,
    input  logic [31:0] v_R2_M,
    input  logic [31:0] v_WB_M,
    input  logic [4:0]  a_WB_M,
    output logic        stall_M,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [3:0]  m_be,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic [31:0] instr_W,
    output logic        valid_W,
    output logic [31:0] v_WB_W,
    output logic [4:0]  a_WB_W,
    output logic        bus_err_W,
`ifdef ALIGN_EXC_EN
    output logic        adel_W,
    output logic        ades_W,
    output logic [31:0] badvaddr_W,
`endif
    output logic        dbg_state
);
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

    state_t     state;
    logic [7:0] count;

    logic is_load, is_store, is_byte, is_half, is_unsigned;
    logic misalign, mem_op, abort;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    always_comb begin
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_byte     = 1'b0;
        is_half     = 1'b0;
        is_unsigned = 1'b0;
        case (instr_M[31:26])
            6'b100011: is_load = 1'b1;
            6'b100001: begin is_load = 1'b1; is_half = 1'b1; end
            6'b100101: begin is_load = 1'b1; is_half = 1'b1; is_unsigned = 1'b1; end
            6'b100000: begin is_load = 1'b1; is_byte = 1'b1; end
            6'b100100: begin is_load = 1'b1; is_byte = 1'b1; is_unsigned = 1'b1; end
            6'b101011: is_store = 1'b1;
            6'b101001: begin is_store = 1'b1; is_half = 1'b1; end
            6'b101000: begin is_store = 1'b1; is_byte = 1'b1; end
            default: ;
        endcase
    end

`ifdef ALIGN_EXC_EN
    assign misalign = is_half ? v_ALUout_M[0] : (~is_byte & (v_ALUout_M[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign mem_op = valid_M & (is_load | is_store) & ~misalign;
    // Handshake: m_req stays high with stable addr/be/wdata until the cycle m_ack is seen
    // (or the wait budget expires); m_ack in a cycle without m_req is ignored.
    assign abort     = (state == S_WAIT) & (count == MAX_CNT) & mem_op & ~m_ack;
    assign m_req     = reset & mem_op;
    assign stall_M   = reset & mem_op & ~m_ack & ~abort;
    assign m_we      = mem_op & is_store;
    assign m_addr    = {v_ALUout_M[31:2], 2'b00};
    assign dbg_state = (state == S_WAIT);

    always_comb begin
        m_be    = 4'b1111;
        m_wdata = v_R2_M;
        if (is_store && is_byte) begin
            m_be    = 4'b0001 << v_ALUout_M[1:0];
            m_wdata = {4{v_R2_M[7:0]}};
        end else if (is_store && is_half) begin
            m_be    = v_ALUout_M[1] ? 4'b1100 : 4'b0011;
            m_wdata = {2{v_R2_M[15:0]}};
        end
    end

    // Little-endian lane select from the returned word.
    assign byte_sel = m_rdata[8*v_ALUout_M[1:0] +: 8];
    assign half_sel = v_ALUout_M[1] ? m_rdata[31:16] : m_rdata[15:0];

    always_comb begin
        load_data = m_rdata;
        if (is_byte)
            load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        else if (is_half)
            load_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            count     <= 8'd0;
            instr_W   <= 32'd0;
            valid_W   <= 1'b0;
            v_WB_W    <= 32'd0;
            a_WB_W    <= 5'd0;
            bus_err_W <= 1'b0;
`ifdef ALIGN_EXC_EN
            adel_W     <= 1'b0;
            ades_W     <= 1'b0;
            badvaddr_W <= 32'd0;
`endif
        end else begin
            case (state)
                S_IDLE: if (mem_op && !m_ack) begin
                    state <= S_WAIT;
                    count <= 8'd1;
                end
                S_WAIT: if (!mem_op || m_ack || abort) begin
                    state <= S_IDLE;
                    count <= 8'd0;
                end else begin
                    count <= count + 8'd1;
                end
                default: state <= S_IDLE;
            endcase

            if (stall_M) begin
                instr_W   <= 32'd0;
                valid_W   <= 1'b0;
                v_WB_W    <= 32'd0;
                a_WB_W    <= 5'd0;
                bus_err_W <= 1'b0;
            end else if (abort) begin
                instr_W   <= instr_M;
                valid_W   <= 1'b1;
                v_WB_W    <= 32'd0;
                a_WB_W    <= 5'd0;
                bus_err_W <= 1'b1;
            end else begin
                instr_W   <= instr_M;
                valid_W   <= valid_M;
                v_WB_W    <= (mem_op && is_load) ? load_data : v_WB_M;
                a_WB_W    <= (valid_M && misalign) ? 5'd0 : a_WB_M;
                bus_err_W <= 1'b0;
            end
`ifdef ALIGN_EXC_EN
            adel_W <= valid_M & is_load & misalign;
            ades_W <= valid_M & is_store & misalign;
            if (valid_M && misalign)
                badvaddr_W <= v_ALUout_M;
`endif
        end
    end
endmodule

// File: doc/stage_m_mem.md
Name: stage_m_mem

Overview:
- Memory (M) pipeline stage of the 5-stage MIPS core; sits directly downstream of the execute stage.
- Consumes the execute stage's ALU result (effective address), forwarded rt value (store data), write-back value/address and instruction.
- Drives a req/ack data-memory port that may take several cycles, aligns store data, sign/zero-extends load data, and owns the M/W pipeline register.
- Raises a stall while a memory access is outstanding.

Parameters:
- MAX_WAIT, 16: cycles allowed between request and ack before the access is aborted as a bus error (1..255).

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- instr_M  in  32  instruction in M stage
- valid_M  in  1  instr_M is a real instruction (0 = bubble)
- v_ALUout_M  in  32  effective address / ALU result
- v_R2_M  in  32  store data (already forwarded)
- v_WB_M  in  32  write-back value from execute stage
- a_WB_M  in  5  write-back register (0 = none)
- stall_M  out  1  hold M and all upstream stages
- m_req  out  1  memory request
- m_we  out  1  write request
- m_addr  out  32  word address, {v_ALUout_M[31:2],2'b00}
- m_be  out  4  byte enables
- m_wdata  out  32  aligned store data
- m_ack  in  1  access complete; m_rdata valid for reads
- m_rdata  in  32  read word
- instr_W  out  32  M/W register: instruction
- valid_W  out  1  M/W register: valid
- v_WB_W  out  32  M/W register: write-back value
- a_WB_W  out  5  M/W register: write-back register
- bus_err_W  out  1  M/W register: access timed out

Behaviour:
- Decode from instr_M[31:26]:
  - loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100
  - stores: sw 101011, sh 101001, sb 101000
  - mem_op = valid_M & (load | store); all other opcodes pass through with no bus activity.
- FSM states:
  - IDLE: mem_op & ~m_ack -> WAIT, counter cleared to 1; mem_op & m_ack -> stays IDLE (single-cycle access).
  - WAIT: m_ack -> IDLE; counter == MAX_WAIT & ~m_ack -> IDLE with abort; otherwise counter+1.
- m_req = mem_op & (state==IDLE | state==WAIT). m_addr/m_we/m_be/m_wdata are combinational from the held M inputs, stable while stall_M=1.
- stall_M = mem_op & ~m_ack & ~abort, where abort = WAIT & counter==MAX_WAIT.
- Store alignment:
  - sw: be=1111, wdata=v_R2_M
  - sh: be = addr[1] ? 1100 : 0011; wdata = {2{v_R2_M[15:0]}}
  - sb: be = 0001<<addr[1:0]; wdata = {4{v_R2_M[7:0]}}
- Loads: m_be=1111, m_we=0. Byte select by addr[1:0], halfword select by addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes m_rdata.
- M/W register updates every edge:
  - stall_M=1: capture bubble (valid_W=0, a_WB_W=0, v_WB_W=0, instr_W=0, bus_err_W=0).
  - completed load: v_WB_W = extended data, a_WB_W = a_WB_M.
  - store or non-mem: v_WB_W = v_WB_M, a_WB_W = a_WB_M.
  - abort: capture instr, valid_W=1, a_WB_W=0, bus_err_W=1 for one cycle.
- Latency: M->W one edge after completion; access ack'd in request cycle adds 0 stall cycles; ack N cycles after request adds N stall cycles.
- m_ack outside m_req is ignored.
- Reset (any time, including mid-access): state=IDLE, counter=0, all W outputs 0. m_req drops immediately; the memory side must tolerate abandoned requests.

Optional Feature:
- Macro ALIGN_EXC_EN.
- Defined: misaligned access is never issued.
  - Misaligned means lw/sw with addr[1:0]!=0, or lh/lhu/sh with addr[0]!=0.
  - m_req=0, stall_M=0; W captures the instruction with a_WB_W=0.
  - Extra output port adel_W (misaligned load) / ades_W (misaligned store), 1-cycle pulse, with badvaddr_W = v_ALUout_M (32 bits, held until the next exception).
- Undefined: low address bits are ignored for width alignment (lw/sw use word addr[31:2]; halfword uses addr[1]); no extra ports.

Test Plan:
- sb: v_R2_M=0x000000AB, addr 0x1003, ack same cycle -> m_be=1000, m_wdata=0xABABABAB, m_we=1, stall_M=0, next cycle a_WB_W=0.
- lb: addr 0x2002, m_rdata=0x1280_3456, ack after 3 cycles -> stall_M high 3 cycles with W bubbles, then v_WB_W=0xFFFFFF80; repeat as lbu -> 0x00000080.
- lh: addr 0x2002, m_rdata=0x8001_0000 -> v_WB_W=0xFFFF8001; lhu -> 0x00008001.
- Non-mem addu: v_WB_M=0x55, a_WB_M=8 -> no m_req, v_WB_W=0x55, a_WB_W=8 next edge.
- Timeout: lw, m_ack never -> stall exactly MAX_WAIT (16) cycles, then bus_err_W=1, a_WB_W=0, FSM back to IDLE.
- Reset low mid-WAIT -> m_req, stall_M, all W outputs 0 immediately; after release a new lw with immediate ack completes normally.
